// File: rtl/light_pkg.sv
// Shared colour codes, FSM encodings and defaults for the light sequence transmitter.
package light_pkg;

  localparam int unsigned DUR_W_DEF      = 6;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned COLOR_W        = 2;
  localparam int unsigned STATE_W        = 4;

  typedef enum logic [COLOR_W-1:0] {
    COL_OFF    = 2'b00,
    COL_GREEN  = 2'b01,
    COL_YELLOW = 2'b10,
    COL_RED    = 2'b11
  } color_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 4'd0,
    ST_EMIT = 4'd1,
    ST_DONE = 4'd2
  } state_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lights_t;

  // One-hot light pattern for a colour; off maps to all lines low.
  function automatic lights_t color_lights(input color_e c);
    lights_t l;
    l = '0;
    case (c)
      COL_GREEN:  l.green  = 1'b1;
      COL_YELLOW: l.yellow = 1'b1;
      COL_RED:    l.red    = 1'b1;
      default:    l        = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/light_cmd_fifo.sv
// Segment command FIFO: registered occupancy flags, flush wins over push and pop.
module light_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready,
  output logic             nonempty_next_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  // Ready comes from the registered count only, so a full FIFO never accepts.
  assign do_push = push & ready_q & ~flush;
  assign do_pop  = pop & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    empty_d = (count_d == '0);
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata           = mem_q[rd_ptr_q];
  assign empty           = empty_q;
  assign ready           = ready_q;
  assign nonempty_next_c = ~empty_d;

endmodule

// File: rtl/light_sequence_tx.sv
// Drives one-hot green/yellow/red lines from queued {colour, duration} segments, back to back.
module light_sequence_tx
  import light_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned DUR_W      = DUR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_color,
  input  logic [DUR_W-1:0]   cmd_dur,
  output logic               cmd_ready,
  input  logic               abort,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic               busy,
  output logic               seq_done,
  output logic [3:0]         current_state,
  output logic [DUR_W-1:0]   timer
);

  localparam int unsigned CMD_W = COLOR_W + DUR_W;

  state_e           state_q, state_d;
  logic [DUR_W-1:0] timer_q, timer_d;
  lights_t          lights_q, lights_d;
  logic             seq_done_q, seq_done_d;
  logic             busy_q, busy_d;

  logic             fifo_ready, fifo_empty, fifo_nonempty_next_c;
  logic [CMD_W-1:0] fifo_rdata;
  logic             push_c, pop_c;
  color_e           head_color_c;
  logic [DUR_W-1:0] head_dur_c, head_timer_c;

  // abort discards a same-cycle push; the FIFO flushes on the same edge.
  assign push_c = cmd_valid & fifo_ready & ~abort;

  light_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock           (clock),
    .reset           (reset),
    .push            (push_c),
    .pop             (pop_c),
    .flush           (abort),
    .wdata           ({cmd_color, cmd_dur}),
    .rdata           (fifo_rdata),
    .empty           (fifo_empty),
    .ready           (fifo_ready),
    .nonempty_next_c (fifo_nonempty_next_c)
  );

  assign head_color_c = color_e'(fifo_rdata[CMD_W-1 -: COLOR_W]);
  assign head_dur_c   = fifo_rdata[DUR_W-1:0];
  // Duration 0 is shown for one cycle, same as duration 1.
  assign head_timer_c = (head_dur_c == '0) ? '0 : head_dur_c - DUR_W'(1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lights_d   = lights_q;
    seq_done_d = 1'b0;
    pop_c      = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      timer_d  = '0;
      lights_d = '0;
    end else begin
      case (state_q)
        ST_EMIT: begin
          if (timer_q != '0) begin
            timer_d = timer_q - DUR_W'(1);
          end else if (!fifo_empty) begin
            // Next segment loads on the final edge of this one: no gap cycle.
            pop_c    = 1'b1;
            timer_d  = head_timer_c;
            lights_d = color_lights(head_color_c);
          end else begin
            state_d    = ST_DONE;
            timer_d    = '0;
            lights_d   = '0;
            seq_done_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d  = ST_IDLE;
          timer_d  = '0;
          lights_d = '0;
        end
        default: begin
          // Covers IDLE and any unreachable encoding.
          state_d  = ST_IDLE;
          timer_d  = '0;
          lights_d = '0;
          if (!fifo_empty) begin
            pop_c    = 1'b1;
            state_d  = ST_EMIT;
            timer_d  = head_timer_c;
            lights_d = color_lights(head_color_c);
          end
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE) | fifo_nonempty_next_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      lights_q   <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lights_q   <= lights_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready     = fifo_ready;
  assign green         = lights_q.green;
  assign yellow        = lights_q.yellow;
  assign red           = lights_q.red;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;
  assign current_state = 4'(state_q);
  assign timer         = timer_q;

endmodule

// File: tb/tb_light_sequence_tx.sv
// Bench for light_sequence_tx: segment-level model checked every cycle plus literal pins.
module tb_light_sequence_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [1:0]    cmd_color;
  logic [DW-1:0] cmd_dur;
  logic          cmd_ready;
  logic          abort;
  logic          green, yellow, red, busy, seq_done;
  logic [3:0]    current_state;
  logic [DW-1:0] timer;

  light_sequence_tx #(.FIFO_DEPTH(DEPTH), .DUR_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_color     (cmd_color),
    .cmd_dur       (cmd_dur),
    .cmd_ready     (cmd_ready),
    .abort         (abort),
    .green         (green),
    .yellow        (yellow),
    .red           (red),
    .busy          (busy),
    .seq_done      (seq_done),
    .current_state (current_state),
    .timer         (timer)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending segments, cycles left on the shown colour, done-cycle flag.
  typedef struct { int col; int len; } seg_t;
  seg_t m_q[$];
  seg_t m_s;
  int   m_rem;
  int   m_col;
  bit   m_done;
  bit   m_last_accept;
  int   m_q0;
  bit   m_load;

  // Run log of what the DUT actually shows, used by the literal checks.
  typedef struct { int col; int len; } run_t;
  run_t runs[$];
  int   prev_col, run_len, cyc, done_cnt, first_on_cyc, done_cyc;
  bit   ready_low_seen;
  int   cur_col;

  task automatic clear_log();
    runs.delete();
    prev_col       = 0;
    run_len        = 0;
    done_cnt       = 0;
    first_on_cyc   = -1;
    done_cyc       = -1;
    ready_low_seen = 1'b0;
  endtask

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      m_q.delete();
      m_rem         = 0;
      m_col         = 0;
      m_done        = 1'b0;
      m_last_accept = 1'b0;
    end else begin
      check("green",     32'(green),         32'(m_rem > 0 && m_col == 1));
      check("yellow",    32'(yellow),        32'(m_rem > 0 && m_col == 2));
      check("red",       32'(red),           32'(m_rem > 0 && m_col == 3));
      check("timer",     32'(timer),         32'(m_rem > 0 ? m_rem - 1 : 0));
      check("seq_done",  32'(seq_done),      32'(m_done));
      check("state",     32'(current_state), 32'(m_rem > 0 ? 1 : (m_done ? 2 : 0)));
      check("busy",      32'(busy),          32'(m_rem > 0 || m_done || m_q.size() > 0));
      check("cmd_ready", 32'(cmd_ready),     32'(m_q.size() < DEPTH));

      cur_col = ({red, yellow, green} == 3'b001) ? 1 :
                ({red, yellow, green} == 3'b010) ? 2 :
                ({red, yellow, green} == 3'b100) ? 3 :
                ({red, yellow, green} == 3'b000) ? 0 : 7;
      if (cur_col != prev_col) begin
        if (prev_col != 0) runs.push_back('{prev_col, run_len});
        if (prev_col == 0 && first_on_cyc < 0) first_on_cyc = cyc;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_col = cur_col;
      if (seq_done) begin done_cnt++; done_cyc = cyc; end
      if (!cmd_ready) ready_low_seen = 1'b1;

      // Advance the model by the coming rising edge.
      m_last_accept = 1'b0;
      if (abort) begin
        m_q.delete();
        m_rem  = 0;
        m_done = 1'b0;
      end else begin
        m_q0   = m_q.size();
        m_load = 1'b0;
        if (m_rem > 1) m_rem--;
        else if (m_rem == 1) begin
          if (m_q0 > 0) m_load = 1'b1;
          else begin m_rem = 0; m_done = 1'b1; end
        end else if (m_done) m_done = 1'b0;
        else if (m_q0 > 0) m_load = 1'b1;
        if (m_load) begin
          m_s   = m_q.pop_front();
          m_col = m_s.col;
          m_rem = (m_s.len == 0) ? 1 : m_s.len;
        end
        if (cmd_valid && m_q0 < DEPTH) begin
          m_q.push_back('{int'(cmd_color), int'(cmd_dur)});
          m_last_accept = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer a command until it is taken; returns 1 ns after the accepting edge.
  task automatic push_cmd(input logic [1:0] c, input int d);
    int budget;
    cmd_valid = 1'b1;
    cmd_color = c;
    cmd_dur   = DW'(d);
    budget    = 200;
    step();
    while (!m_last_accept && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("push_timeout", 32'(0), 32'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 400;
    step();
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("idle_timeout", 32'(busy), 32'(0));
    step();
  endtask

  task automatic check_run(input int idx, input int c, input int l);
    if (idx < runs.size()) begin
      check($sformatf("run%0d_col", idx), 32'(runs[idx].col), 32'(c));
      check($sformatf("run%0d_len", idx), 32'(runs[idx].len), 32'(l));
    end else begin
      check("run_count", 32'(runs.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_color = 2'b00;
    cmd_dur   = '0;
    abort     = 1'b0;
    cyc       = 0;
    clear_log();
    repeat (3) step();
    check("rst_ready",  32'(cmd_ready),     32'(1));
    check("rst_lights", 32'({red, yellow, green}), 32'(0));
    check("rst_state",  32'(current_state), 32'(0));
    check("rst_timer",  32'(timer),         32'(0));
    check("rst_busy",   32'(busy),          32'(0));
    reset = 1'b0;
    step();

    // Green 45 / yellow 21 / green 60, back to back.
    clear_log();
    push_cmd(2'b01, 45);
    push_cmd(2'b10, 21);
    push_cmd(2'b01, 60);
    wait_idle();
    check("t2_runs", 32'(runs.size()), 32'(3));
    check_run(0, 1, 45);
    check_run(1, 2, 21);
    check_run(2, 1, 60);
    check("t2_done_cnt", 32'(done_cnt), 32'(1));
    check("t2_span",     32'(done_cyc - first_on_cyc), 32'(126));

    // Red with duration 0: one cycle of red, then the done pulse.
    clear_log();
    push_cmd(2'b11, 0);
    check("t3_wait_red",  32'(red), 32'(0));
    step();
    check("t3_red_on",    32'(red), 32'(1));
    check("t3_timer",     32'(timer), 32'(0));
    step();
    check("t3_red_off",   32'(red), 32'(0));
    check("t3_done",      32'(seq_done), 32'(1));
    check("t3_state_done", 32'(current_state), 32'(2));
    step();
    check("t3_done_low",  32'(seq_done), 32'(0));
    check("t3_idle_busy", 32'(busy), 32'(0));
    step();

    // Back-pressure while emitting green 10: full FIFO stalls, order kept.
    clear_log();
    push_cmd(2'b01, 10);
    push_cmd(2'b10, 3);
    push_cmd(2'b11, 4);
    push_cmd(2'b01, 5);
    push_cmd(2'b10, 6);
    push_cmd(2'b11, 7);
    push_cmd(2'b01, 8);
    wait_idle();
    check("t4_ready_low", 32'(ready_low_seen), 32'(1));
    check("t4_runs", 32'(runs.size()), 32'(7));
    check_run(0, 1, 10);
    check_run(1, 2, 3);
    check_run(2, 3, 4);
    check_run(3, 1, 5);
    check_run(4, 2, 6);
    check_run(5, 3, 7);
    check_run(6, 1, 8);

    // Abort in cycle 5 of yellow 20 with two queued; same-cycle push discarded.
    clear_log();
    push_cmd(2'b10, 20);
    push_cmd(2'b01, 5);
    push_cmd(2'b11, 6);
    repeat (3) step();
    check("t5_yellow", 32'(yellow), 32'(1));
    check("t5_timer",  32'(timer),  32'(15));
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_color = 2'b11;
    cmd_dur   = DW'(7);
    step();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("t5_lights", 32'({red, yellow, green}), 32'(0));
    check("t5_timer0", 32'(timer), 32'(0));
    check("t5_state",  32'(current_state), 32'(0));
    check("t5_busy",   32'(busy), 32'(0));
    check("t5_ready",  32'(cmd_ready), 32'(1));
    repeat (4) step();
    check("t5_no_done", 32'(done_cnt), 32'(0));
    push_cmd(2'b01, 3);
    wait_idle();
    check_run(0, 2, 5);
    check_run(1, 1, 3);
    check("t5_done_after", 32'(done_cnt), 32'(1));

    // Reset in the middle of a green segment with a queued yellow.
    clear_log();
    push_cmd(2'b01, 10);
    push_cmd(2'b10, 5);
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    check("t1_lights", 32'({red, yellow, green}), 32'(0));
    check("t1_state",  32'(current_state), 32'(0));
    check("t1_timer",  32'(timer), 32'(0));
    check("t1_ready",  32'(cmd_ready), 32'(1));
    check("t1_done",   32'(seq_done), 32'(0));
    repeat (2) step();
    #2;
    reset = 1'b0;
    step();
    clear_log();
    push_cmd(2'b11, 2);
    wait_idle();
    check("t1_after_runs", 32'(runs.size()), 32'(1));
    check_run(0, 3, 2);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
